captura_ctrl: RTL

- Sequences the camera pixel capture stage: arms on a software/button request, aligns to a frame boundary, turns the RGB565 pixel stream into framebuffer writes (RGB332) and reports completion/errors.
- Sits between the camera pixel-capture module (pixel_data/pixel_valid/frame_done) and the dual-port framebuffer RAM write port.
- Supports single-shot and continuous capture and a synchronous abort.

---
 rtl/captura_defs.sv | 20 ++
 rtl/rgb565_a_rgb332.sv | 14 +
 rtl/captura_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/captura_defs.sv
// rtl/captura_defs.sv - shared state encodings, defaults and pixel format helper for capture control
package captura_defs;

    localparam int DEF_H_RES  = 160;
    localparam int DEF_V_RES  = 120;
    localparam int DEF_ADDR_W = 15;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } capture_state_t;

    // Keep the top bits of each colour channel: R[15:13], G[10:8], B[4:3].
    function automatic logic [7:0] rgb565_to_rgb332(input logic [15:0] pixel);
        return {pixel[15:13], pixel[10:8], pixel[4:3]};
    endfunction

endpackage

// File: rtl/rgb565_a_rgb332.sv
// rtl/rgb565_a_rgb332.sv - combinational RGB565 to RGB332 converter
module rgb565_a_rgb332
    import captura_defs::*;
(
    input  logic [15:0] rgb565,
    output logic [7:0]  rgb332
);

    // Pure bit selection; shared helper keeps the readback path consistent.
    always_comb begin
        rgb332 = rgb565_to_rgb332(rgb565);
    end

endmodule

// File: rtl/captura_ctrl.sv
// rtl/captura_ctrl.sv - camera capture sequencer writing RGB332 pixels into the framebuffer
module captura_ctrl
    import captura_defs::*;
#(
    parameter int H_RES  = DEF_H_RES,
    parameter int V_RES  = DEF_V_RES,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              p_clock,
    input  logic              rst,
    input  logic              start,
    input  logic              continuous,
    input  logic              abort,
    input  logic [15:0]       pixel_data,
    input  logic              pixel_valid,
    input  logic              frame_done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              busy,
    output logic              done,
    output logic [7:0]        frame_count,
    output logic              err_short,
    output logic              err_overflow
);

    // One extra counter bit so a completely full frame is still representable.
    localparam logic [ADDR_W:0] TOTAL = (ADDR_W + 1)'(H_RES * V_RES);

    capture_state_t  state;
    capture_state_t  state_next;
    logic [ADDR_W:0] pixel_count;
    logic [ADDR_W:0] count_after;
    logic            mode_continuous;
    logic            pixel_accept;
    logic [7:0]      pixel_rgb332;

    rgb565_a_rgb332 u_convert (
        .rgb565 (pixel_data),
        .rgb332 (pixel_rgb332)
    );

    // A pixel is only stored while the frame still has room; the count after it decides err_short.
    always_comb begin
        pixel_accept = pixel_valid && (pixel_count < TOTAL);
        count_after  = pixel_count + {{ADDR_W{1'b0}}, pixel_accept};
    end

    // State register.
    always_ff @(posedge p_clock or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_next = state;
        busy       = (state == ST_SYNC) || (state == ST_CAPTURE);
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (frame_done) begin
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (frame_done) begin
                    state_next = mode_continuous ? ST_CAPTURE : ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (abort) begin
            state_next = ST_IDLE;
        end
    end

    // Datapath: write port, pixel counter, frame statistics and sticky error flags.
    always_ff @(posedge p_clock or posedge rst) begin
        if (rst) begin
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_data        <= '0;
            done            <= 1'b0;
            frame_count     <= '0;
            err_short       <= 1'b0;
            err_overflow    <= 1'b0;
            pixel_count     <= '0;
            mode_continuous <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            if (!abort) begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            mode_continuous <= continuous;
                            frame_count     <= '0;
                            err_short       <= 1'b0;
                            err_overflow    <= 1'b0;
                            pixel_count     <= '0;
                        end
                    end
                    ST_SYNC: begin
                        if (frame_done) begin
                            pixel_count <= '0;
                        end
                    end
                    ST_CAPTURE: begin
                        if (pixel_accept) begin
                            mem_we   <= 1'b1;
                            mem_addr <= pixel_count[ADDR_W-1:0];
                            mem_data <= pixel_rgb332;
                        end
                        if (pixel_valid && !pixel_accept) begin
                            err_overflow <= 1'b1;
                        end
                        if (frame_done) begin
                            if (count_after < TOTAL) begin
                                err_short <= 1'b1;
                            end
                            done        <= 1'b1;
                            frame_count <= frame_count + 8'd1;
                            pixel_count <= '0;
                        end else begin
                            pixel_count <= count_after;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
